// File: rtl/fight_controller_pkg.sv
// fight_controller_pkg: shared encodings, damage table and small helpers for the
// battle-scene sequencer and the fight renderer.
package fight_controller_pkg;

    // fight_state encoding; the renderer decodes the same values
    typedef enum logic [5:0] {
        ST_MENU    = 6'd1,
        ST_SKILL   = 6'd2,
        ST_ANIM_P1 = 6'd3,
        ST_ANIM_P2 = 6'd4,
        ST_HP_P1   = 6'd5,
        ST_HP_P2   = 6'd6,
        ST_P1_WIN  = 6'd7,
        ST_P2_WIN  = 6'd8
    } fight_state_e;

    // The single key applied in a cycle after priority resolution
    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_ENTER = 3'd1,
        KEY_BACK  = 3'd2,
        KEY_UP    = 3'd3,
        KEY_DOWN  = 3'd4,
        KEY_LEFT  = 3'd5,
        KEY_RIGHT = 3'd6
    } key_e;

    // option_state encoding: 2x2 grid, 1 2 / 3 4
    localparam logic [3:0] OPT_1 = 4'd1;
    localparam logic [3:0] OPT_2 = 4'd2;
    localparam logic [3:0] OPT_3 = 4'd3;
    localparam logic [3:0] OPT_4 = 4'd4;

    // p2_skill value before P2 has taken any turn
    localparam logic [3:0] SKILL_NONE = 4'd0;

    // Grid index bits: bit0 is the column, bit1 is the row
    localparam logic [1:0] FLIP_COL = 2'b01;
    localparam logic [1:0] FLIP_ROW = 2'b10;

    // Damage of skill/option 1..4
    localparam logic [7:0] DMG1 = 8'd10;
    localparam logic [7:0] DMG2 = 8'd20;
    localparam logic [7:0] DMG3 = 8'd30;
    localparam logic [7:0] DMG4 = 8'd45;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam int         CNT_W     = 25;

    // Damage lookup; anything outside 1..4 deals nothing
    function automatic logic [7:0] dmg_of(input logic [3:0] opt);
        logic [7:0] dmg;
        case (opt)
            OPT_1:   dmg = DMG1;
            OPT_2:   dmg = DMG2;
            OPT_3:   dmg = DMG3;
            OPT_4:   dmg = DMG4;
            default: dmg = 8'd0;
        endcase
        return dmg;
    endfunction

    // Toggle row and/or column of a 1-based grid option
    function automatic logic [3:0] opt_toggle(input logic [3:0] opt, input logic [1:0] flip);
        logic [3:0] idx;
        idx = (opt - 4'd1) ^ {2'b00, flip};
        return (idx & 4'd3) + 4'd1;
    endfunction

    // 8-bit Fibonacci LFSR, taps 8,6,5,4
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

endpackage

// File: rtl/fight_controller_if.sv
// fight_controller_if: key/start inputs and renderer-facing outputs of the battle sequencer.
interface fight_controller_if;

    logic       start;
    logic       key_up;
    logic       key_down;
    logic       key_left;
    logic       key_right;
    logic       key_enter;
    logic       key_back;
    logic [5:0] fight_state;
    logic [3:0] option_state;
    logic [7:0] p1_cur_hp;
    logic [7:0] p2_cur_hp;
    logic [3:0] p2_skill;

    // Input side (keyboard / scene control) drives pulses and observes the scene
    modport master (
        output start, key_up, key_down, key_left, key_right, key_enter, key_back,
        input  fight_state, option_state, p1_cur_hp, p2_cur_hp, p2_skill
    );

    // Sequencer side
    modport slave (
        input  start, key_up, key_down, key_left, key_right, key_enter, key_back,
        output fight_state, option_state, p1_cur_hp, p2_cur_hp, p2_skill
    );

endinterface

// File: rtl/fight_hp_drain.sv
// fight_hp_drain: one HP register with full-load and saturating single-point decrement.
module fight_hp_drain
#(
    parameter int MAX_HP = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       step_i,
    output logic [7:0] hp_o
);

    localparam logic [7:0] HP_FULL = 8'(MAX_HP);

    logic [7:0] hp_d;
    logic [7:0] hp_q;

    // Next HP: load wins over step, and a step at zero leaves HP at zero
    always_comb begin
        hp_d = hp_q;
        if (load_i) begin
            hp_d = HP_FULL;
        end else if (step_i && (hp_q != 8'd0)) begin
            hp_d = hp_q - 8'd1;
        end else begin
            hp_d = hp_q;
        end
    end

    // HP register, full on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hp_q <= HP_FULL;
        end else begin
            hp_q <= hp_d;
        end
    end

    assign hp_o = hp_q;

endmodule

// File: rtl/fight_controller.sv
// fight_controller: battle-scene sequencer. Menu/skill navigation, P1 and P2
// attack animations, timed HP drain, LFSR-driven P2 skill choice and KO detection.
module fight_controller
    import fight_controller_pkg::*;
#(
    parameter int MAX_HP         = 200,
    parameter int ANIM_CYCLES    = 25_000_000,
    parameter int HP_STEP_CYCLES = 500_000
) (
    input  logic              clk,
    input  logic              rst_n,
    fight_controller_if.slave bus
);

    localparam logic [CNT_W-1:0] ANIM_LAST = CNT_W'(ANIM_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(HP_STEP_CYCLES - 1);

    fight_state_e     state_q;
    fight_state_e     state_d;
    logic [3:0]       opt_q;
    logic [3:0]       opt_d;
    logic [3:0]       skill_q;
    logic [3:0]       skill_d;
    logic [7:0]       dmg_q;
    logic [7:0]       dmg_d;
    logic [7:0]       lfsr_q;
    logic [7:0]       lfsr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    key_e       key_s;
    logic       timed_s;
    logic       term_s;
    logic       drain_done_s;
    logic       reinit_s;
    logic       step_p1_s;
    logic       step_p2_s;
    logic [7:0] drain_hp_s;
    logic [7:0] p1_hp_s;
    logic [7:0] p2_hp_s;
    logic [3:0] new_skill_s;

    // Resolve simultaneous key pulses to the single highest-priority key
    always_comb begin
        key_s = KEY_NONE;
        if (bus.key_enter) begin
            key_s = KEY_ENTER;
        end else if (bus.key_back) begin
            key_s = KEY_BACK;
        end else if (bus.key_up) begin
            key_s = KEY_UP;
        end else if (bus.key_down) begin
            key_s = KEY_DOWN;
        end else if (bus.key_left) begin
            key_s = KEY_LEFT;
        end else if (bus.key_right) begin
            key_s = KEY_RIGHT;
        end else begin
            key_s = KEY_NONE;
        end
    end

    // Timer terminal count and drain-exit detection for the timed states
    always_comb begin
        timed_s      = 1'b0;
        term_s       = 1'b0;
        drain_hp_s   = 8'd0;
        drain_done_s = 1'b0;
        case (state_q)
            ST_ANIM_P1, ST_ANIM_P2: begin
                timed_s = 1'b1;
                term_s  = (cnt_q == ANIM_LAST);
            end
            ST_HP_P1: begin
                timed_s      = 1'b1;
                term_s       = (cnt_q == STEP_LAST);
                drain_hp_s   = p1_hp_s;
                drain_done_s = term_s && ((dmg_q == 8'd0) || (p1_hp_s == 8'd0));
            end
            ST_HP_P2: begin
                timed_s      = 1'b1;
                term_s       = (cnt_q == STEP_LAST);
                drain_hp_s   = p2_hp_s;
                drain_done_s = term_s && ((dmg_q == 8'd0) || (p2_hp_s == 8'd0));
            end
            default: begin
                timed_s = 1'b0;
                term_s  = 1'b0;
            end
        endcase
    end

    // Full reinit (start, or enter on a result screen) and per-player drain steps
    always_comb begin
        reinit_s  = bus.start ||
                    (((state_q == ST_P1_WIN) || (state_q == ST_P2_WIN)) && (key_s == KEY_ENTER));
        step_p1_s = !bus.start && (state_q == ST_HP_P1) && term_s && !drain_done_s;
        step_p2_s = !bus.start && (state_q == ST_HP_P2) && term_s && !drain_done_s;
        new_skill_s = {2'b00, lfsr_q[1:0]} + 4'd1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_MENU;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start overrides every key and timer
    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = ST_MENU;
        end else begin
            case (state_q)
                ST_MENU: begin
                    if ((key_s == KEY_ENTER) && (opt_q == OPT_1)) state_d = ST_SKILL;
                    else                                          state_d = ST_MENU;
                end
                ST_SKILL: begin
                    if (key_s == KEY_ENTER)     state_d = ST_ANIM_P1;
                    else if (key_s == KEY_BACK) state_d = ST_MENU;
                    else                        state_d = ST_SKILL;
                end
                ST_ANIM_P1: begin
                    if (term_s) state_d = ST_HP_P2;
                    else        state_d = ST_ANIM_P1;
                end
                ST_HP_P2: begin
                    if (drain_done_s) state_d = (drain_hp_s == 8'd0) ? ST_P1_WIN : ST_ANIM_P2;
                    else              state_d = ST_HP_P2;
                end
                ST_ANIM_P2: begin
                    if (term_s) state_d = ST_HP_P1;
                    else        state_d = ST_ANIM_P2;
                end
                ST_HP_P1: begin
                    if (drain_done_s) state_d = (drain_hp_s == 8'd0) ? ST_P2_WIN : ST_MENU;
                    else              state_d = ST_HP_P1;
                end
                ST_P1_WIN, ST_P2_WIN: begin
                    if (key_s == KEY_ENTER) state_d = ST_MENU;
                    else                    state_d = state_q;
                end
                default: state_d = ST_MENU;
            endcase
        end
    end

    // FSM output logic: next values of option, damage, P2 skill, timer and LFSR
    always_comb begin
        opt_d   = opt_q;
        dmg_d   = dmg_q;
        skill_d = skill_q;
        lfsr_d  = lfsr_next(lfsr_q);
        if (reinit_s || (state_d != state_q) || !timed_s || term_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (reinit_s) begin
            opt_d   = OPT_1;
            dmg_d   = 8'd0;
            skill_d = SKILL_NONE;
        end else begin
            case (state_q)
                ST_MENU, ST_SKILL: begin
                    case (key_s)
                        KEY_ENTER: begin
                            if (state_q == ST_SKILL) dmg_d = dmg_of(opt_q);
                            else                     dmg_d = dmg_q;
                        end
                        KEY_BACK: begin
                            if (state_q == ST_SKILL) opt_d = OPT_1;
                            else                     opt_d = opt_q;
                        end
                        KEY_UP, KEY_DOWN:    opt_d = opt_toggle(opt_q, FLIP_ROW);
                        KEY_LEFT, KEY_RIGHT: opt_d = opt_toggle(opt_q, FLIP_COL);
                        default:             opt_d = opt_q;
                    endcase
                end
                ST_HP_P2: begin
                    if (state_d == ST_ANIM_P2) begin
                        // P2 picks its skill on entry to its animation
                        skill_d = new_skill_s;
                        dmg_d   = dmg_of(new_skill_s);
                    end else if (step_p2_s) begin
                        dmg_d = dmg_q - 8'd1;
                    end else begin
                        dmg_d = dmg_q;
                    end
                end
                ST_HP_P1: begin
                    if (state_d == ST_MENU) begin
                        opt_d = OPT_1;
                    end else if (step_p1_s) begin
                        dmg_d = dmg_q - 8'd1;
                    end else begin
                        dmg_d = dmg_q;
                    end
                end
                default: begin
                    opt_d = opt_q;
                    dmg_d = dmg_q;
                end
            endcase
        end
    end

    // Datapath registers; the LFSR reseeds on reset only and runs through start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opt_q   <= OPT_1;
            dmg_q   <= 8'd0;
            skill_q <= SKILL_NONE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            opt_q   <= opt_d;
            dmg_q   <= dmg_d;
            skill_q <= skill_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    fight_hp_drain #(.MAX_HP(MAX_HP)) u_p1_hp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (reinit_s),
        .step_i (step_p1_s),
        .hp_o   (p1_hp_s)
    );

    fight_hp_drain #(.MAX_HP(MAX_HP)) u_p2_hp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (reinit_s),
        .step_i (step_p2_s),
        .hp_o   (p2_hp_s)
    );

    assign bus.fight_state  = state_q;
    assign bus.option_state = opt_q;
    assign bus.p1_cur_hp    = p1_hp_s;
    assign bus.p2_cur_hp    = p2_hp_s;
    assign bus.p2_skill     = skill_q;

endmodule
